// File: rtl/ps2_host_seq_if.sv
// Bundle of CPU-side and ps2_port-side signals for the PS2 command/reply sequencer.
// The sequencer uses the slave view; whatever drives it (register block / port model) uses master.
interface ps2_host_seq_if;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic       rdeq_i;
  logic [7:0] wdata_i;
  logic       wlast_i;
  logic       wenq_i;
  logic [7:0] stat_o;
  logic       tx_full_o;
  logic       rx_ovf_o;
  logic       tx_ovf_o;
  logic       ovf_clr_i;
  logic [7:0] ps2_rx_i;
  logic       ps2_rx_v_i;
  logic [7:0] ps2_tx_o;
  logic       ps2_tx_v_o;
  logic       ps2_tx_deq_i;
  logic       ps2_tx_errd_i;

  modport slave (
    output rdata_o, rvalid_o, stat_o, tx_full_o, rx_ovf_o, tx_ovf_o, ps2_tx_o, ps2_tx_v_o,
    input  rdeq_i, wdata_i, wlast_i, wenq_i, ovf_clr_i, ps2_rx_i, ps2_rx_v_i,
           ps2_tx_deq_i, ps2_tx_errd_i
  );

  modport master (
    input  rdata_o, rvalid_o, stat_o, tx_full_o, rx_ovf_o, tx_ovf_o, ps2_tx_o, ps2_tx_v_o,
    output rdeq_i, wdata_i, wlast_i, wenq_i, ovf_clr_i, ps2_rx_i, ps2_rx_v_i,
           ps2_tx_deq_i, ps2_tx_errd_i
  );
endinterface

// File: rtl/ps2_host_seq.sv
// Command/reply sequencer for one PS2 channel: RX byte FIFO, TX command FIFO, and an FSM that
// sends one byte at a time, swallows ACK/RESEND, retries, times out and reports a status code.
module ps2_host_seq #(
  parameter int RXDEPTH_LOG2 = 3,
  parameter int TXDEPTH_LOG2 = 2,
  parameter int MAX_RETRY    = 2,
  parameter int TIMEOUT_US   = 20000
) (
  input  logic          clk6x,
  input  logic          resetn,
  input  logic          ck1us,
  ps2_host_seq_if.slave bus
);
  localparam int RXD = 1 << RXDEPTH_LOG2;
  localparam int TXD = 1 << TXDEPTH_LOG2;
  localparam int RCW = RXDEPTH_LOG2 + 1;
  localparam int TCW = TXDEPTH_LOG2 + 1;
  localparam int TOW = $clog2(TIMEOUT_US + 1);

  localparam logic [TOW-1:0]          TO_LIMIT  = TOW'(TIMEOUT_US);
  localparam logic [TOW-1:0]          TO_ONE    = TOW'(1);
  localparam logic [2:0]              RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [TXDEPTH_LOG2-1:0] TXP_ONE   = TXDEPTH_LOG2'(1);
  localparam logic [TCW-1:0]          TXC_ONE   = TCW'(1);
  localparam logic [TCW-1:0]          TXC_FULL  = TCW'(TXD);
  localparam logic [RXDEPTH_LOG2-1:0] RXP_ONE   = RXDEPTH_LOG2'(1);
  localparam logic [RCW-1:0]          RXC_ONE   = RCW'(1);
  localparam logic [RCW-1:0]          RXC_FULL  = RCW'(RXD);

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ERROR  = 8'hFC;
  localparam logic [7:0] STAT_PEND   = 8'h01;
  localparam logic [7:0] STAT_ERR    = 8'hFE;
  localparam logic [7:0] STAT_TMO    = 8'hFD;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [8:0]              txbuf_reg, txbuf_next;
  logic [2:0]              retry_reg, retry_next;
  logic [TOW-1:0]          to_cnt_reg, to_cnt_next;
  logic [7:0]              stat_reg, stat_next;
  logic                    tx_v_reg, tx_v_next;
  logic                    rx_ovf_reg, rx_ovf_next;
  logic                    tx_ovf_reg, tx_ovf_next;

  logic [8:0]              tx_mem [TXD];
  logic [TXDEPTH_LOG2-1:0] tx_wptr_reg, tx_wptr_next, tx_rptr_reg, tx_rptr_next;
  logic [TCW-1:0]          tx_cnt_reg, tx_cnt_next;
  logic [7:0]              rx_mem [RXD];
  logic [RXDEPTH_LOG2-1:0] rx_wptr_reg, rx_wptr_next, rx_rptr_reg, rx_rptr_next;
  logic [RCW-1:0]          rx_cnt_reg, rx_cnt_next;

  logic tx_empty, tx_full, tx_pop, tx_push, flush, to_clr;
  logic rx_empty, rx_full, rx_pop, rx_push, rx_wr, rx_swallow;
  logic resend_ev, tx_ovf_ev, rx_ovf_ev;

  assign tx_empty = (tx_cnt_reg == '0);
  assign tx_full  = (tx_cnt_reg == TXC_FULL);
  assign rx_empty = (rx_cnt_reg == '0);
  assign rx_full  = (rx_cnt_reg == RXC_FULL);

  // ACK and RESEND are protocol replies only while a byte is outstanding.
  assign rx_swallow = (state_reg == ST_WAIT) && bus.ps2_rx_v_i &&
                      ((bus.ps2_rx_i == BYTE_ACK) || (bus.ps2_rx_i == BYTE_RESEND));
  assign resend_ev  = (bus.ps2_rx_v_i && (bus.ps2_rx_i == BYTE_RESEND)) || bus.ps2_tx_errd_i;

  always_comb begin
    state_next  = state_reg;
    txbuf_next  = txbuf_reg;
    retry_next  = retry_reg;
    stat_next   = stat_reg;
    tx_v_next   = 1'b0;
    tx_pop      = 1'b0;
    flush       = 1'b0;
    to_clr      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          txbuf_next = tx_mem[tx_rptr_reg];
          retry_next = '0;
          stat_next  = STAT_PEND;
          state_next = ST_SEND;
        end
      end
      ST_LOAD: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          txbuf_next = tx_mem[tx_rptr_reg];
          retry_next = '0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        // Request rises one cycle after entering SEND and falls on the consuming edge.
        tx_v_next = 1'b1;
        if (tx_v_reg && bus.ps2_tx_deq_i) begin
          tx_v_next  = 1'b0;
          to_clr     = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.ps2_rx_v_i && (bus.ps2_rx_i == BYTE_ACK)) begin
          if (txbuf_reg[8]) begin
            stat_next  = BYTE_ACK;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_LOAD;
          end
        end else if (bus.ps2_rx_v_i && (bus.ps2_rx_i == BYTE_ERROR)) begin
          stat_next  = STAT_ERR;
          flush      = 1'b1;
          state_next = ST_IDLE;
        end else if (resend_ev) begin
          if (retry_reg < RETRY_MAX) begin
            retry_next = retry_reg + 3'd1;
            state_next = ST_SEND;
          end else begin
            stat_next  = STAT_ERR;
            flush      = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (to_cnt_reg == TO_LIMIT) begin
          stat_next  = STAT_TMO;
          flush      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (to_clr)
      to_cnt_next = '0;
    else if ((state_reg == ST_WAIT) && ck1us && (to_cnt_reg != TO_LIMIT))
      to_cnt_next = to_cnt_reg + TO_ONE;
  end

  // TX FIFO: a pop frees a slot in the same cycle, and a flush discards any concurrent push.
  assign tx_push   = bus.wenq_i && !flush && (!tx_full || tx_pop);
  assign tx_ovf_ev = bus.wenq_i && !flush && tx_full && !tx_pop;

  always_comb begin
    tx_wptr_next = tx_wptr_reg;
    tx_rptr_next = tx_rptr_reg;
    tx_cnt_next  = tx_cnt_reg;
    if (flush) begin
      tx_wptr_next = '0;
      tx_rptr_next = '0;
      tx_cnt_next  = '0;
    end else begin
      if (tx_push) tx_wptr_next = tx_wptr_reg + TXP_ONE;
      if (tx_pop)  tx_rptr_next = tx_rptr_reg + TXP_ONE;
      if (tx_push && !tx_pop)      tx_cnt_next = tx_cnt_reg + TXC_ONE;
      else if (!tx_push && tx_pop) tx_cnt_next = tx_cnt_reg - TXC_ONE;
    end
  end

  assign rx_wr     = bus.ps2_rx_v_i && !rx_swallow;
  assign rx_pop    = bus.rdeq_i && !rx_empty;
  assign rx_push   = rx_wr && (!rx_full || rx_pop);
  assign rx_ovf_ev = rx_wr && rx_full && !rx_pop;

  always_comb begin
    rx_wptr_next = rx_wptr_reg;
    rx_rptr_next = rx_rptr_reg;
    rx_cnt_next  = rx_cnt_reg;
    if (rx_push) rx_wptr_next = rx_wptr_reg + RXP_ONE;
    if (rx_pop)  rx_rptr_next = rx_rptr_reg + RXP_ONE;
    if (rx_push && !rx_pop)      rx_cnt_next = rx_cnt_reg + RXC_ONE;
    else if (!rx_push && rx_pop) rx_cnt_next = rx_cnt_reg - RXC_ONE;
  end

  // A new overflow in the clearing cycle keeps the flag set.
  assign rx_ovf_next = (rx_ovf_reg && !bus.ovf_clr_i) || rx_ovf_ev;
  assign tx_ovf_next = (tx_ovf_reg && !bus.ovf_clr_i) || tx_ovf_ev;

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      txbuf_reg   <= '0;
      retry_reg   <= '0;
      to_cnt_reg  <= '0;
      stat_reg    <= '0;
      tx_v_reg    <= 1'b0;
      rx_ovf_reg  <= 1'b0;
      tx_ovf_reg  <= 1'b0;
      tx_wptr_reg <= '0;
      tx_rptr_reg <= '0;
      tx_cnt_reg  <= '0;
      rx_wptr_reg <= '0;
      rx_rptr_reg <= '0;
      rx_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      txbuf_reg   <= txbuf_next;
      retry_reg   <= retry_next;
      to_cnt_reg  <= to_cnt_next;
      stat_reg    <= stat_next;
      tx_v_reg    <= tx_v_next;
      rx_ovf_reg  <= rx_ovf_next;
      tx_ovf_reg  <= tx_ovf_next;
      tx_wptr_reg <= tx_wptr_next;
      tx_rptr_reg <= tx_rptr_next;
      tx_cnt_reg  <= tx_cnt_next;
      rx_wptr_reg <= rx_wptr_next;
      rx_rptr_reg <= rx_rptr_next;
      rx_cnt_reg  <= rx_cnt_next;
    end
  end

  always_ff @(posedge clk6x) begin
    if (tx_push) tx_mem[tx_wptr_reg] <= {bus.wlast_i, bus.wdata_i};
    if (rx_push) rx_mem[rx_wptr_reg] <= bus.ps2_rx_i;
  end

  assign bus.rdata_o    = rx_empty ? 8'h00 : rx_mem[rx_rptr_reg];
  assign bus.rvalid_o   = !rx_empty;
  assign bus.tx_full_o  = tx_full;
  assign bus.stat_o     = stat_reg;
  assign bus.ps2_tx_o   = txbuf_reg[7:0];
  assign bus.ps2_tx_v_o = tx_v_reg;
  assign bus.rx_ovf_o   = rx_ovf_reg;
  assign bus.tx_ovf_o   = tx_ovf_reg;
endmodule

// File: tb/tb_ps2_host_seq.sv
// Self-checking bench for ps2_host_seq: bench plays CPU and ps2_port/device, with queues of
// expected transmitted bytes and expected RX FIFO bytes.
module tb_ps2_host_seq;
  logic clk6x  = 1'b0;
  logic resetn = 1'b0;
  logic ck1us  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  ps2_host_seq_if bus();

  ps2_host_seq #(
    .RXDEPTH_LOG2(3),
    .TXDEPTH_LOG2(2),
    .MAX_RETRY(2),
    .TIMEOUT_US(50)
  ) dut (
    .clk6x(clk6x),
    .resetn(resetn),
    .ck1us(ck1us),
    .bus(bus)
  );

  always #10 clk6x = ~clk6x;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk6x);
    #1;
  endtask

  task automatic push_cmd(input logic last, input logic [7:0] data);
    bus.wlast_i = last;
    bus.wdata_i = data;
    bus.wenq_i  = 1'b1;
    tick();
    bus.wenq_i  = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    bus.ps2_rx_i   = b;
    bus.ps2_rx_v_i = 1'b1;
    tick();
    bus.ps2_rx_v_i = 1'b0;
  endtask

  task automatic line_err();
    bus.ps2_tx_errd_i = 1'b1;
    tick();
    bus.ps2_tx_errd_i = 1'b0;
  endtask

  task automatic us_pulse();
    ck1us = 1'b1;
    tick();
    ck1us = 1'b0;
    tick();
  endtask

  // Waits (bounded) for a transmit request, consumes it, and pops the expected byte.
  task automatic serve_tx(output logic [7:0] got, output logic [7:0] exp);
    bit ok = 1'b0;
    got = 8'hxx;
    for (int i = 0; i < 40; i++) begin
      if (bus.ps2_tx_v_o === 1'b1) begin
        ok  = 1'b1;
        got = bus.ps2_tx_o;
        break;
      end
      tick();
    end
    if (ok) begin
      bus.ps2_tx_deq_i = 1'b1;
      tick();
      bus.ps2_tx_deq_i = 1'b0;
    end
    exp = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'h00;
  endtask

  task automatic quiet(input int n, output bit seen);
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (bus.ps2_tx_v_o !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic read_rx(output logic [7:0] b, output logic v);
    v = bus.rvalid_o;
    b = bus.rdata_o;
    bus.rdeq_i = 1'b1;
    tick();
    bus.rdeq_i = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    checks++; if (bus.stat_o !== 8'h00)    begin errors++; $display("FAIL reset_stat got %h exp 00", bus.stat_o); end
    checks++; if (bus.ps2_tx_v_o !== 1'b0) begin errors++; $display("FAIL reset_tx_v got %b exp 0", bus.ps2_tx_v_o); end
    checks++; if (bus.ps2_tx_o !== 8'h00)  begin errors++; $display("FAIL reset_tx_o got %h exp 00", bus.ps2_tx_o); end
    checks++; if (bus.rvalid_o !== 1'b0)   begin errors++; $display("FAIL reset_rvalid got %b exp 0", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 8'h00)   begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.rdata_o); end
    checks++; if (bus.tx_full_o !== 1'b0)  begin errors++; $display("FAIL reset_tx_full got %b exp 0", bus.tx_full_o); end
    checks++; if (bus.rx_ovf_o !== 1'b0)   begin errors++; $display("FAIL reset_rx_ovf got %b exp 0", bus.rx_ovf_o); end
    checks++; if (bus.tx_ovf_o !== 1'b0)   begin errors++; $display("FAIL reset_tx_ovf got %b exp 0", bus.tx_ovf_o); end
    resetn = 1'b1;
    tick(2);
    push_cmd(1'b1, 8'h55);
    tick(2);
    checks++; if (bus.ps2_tx_v_o !== 1'b1) begin errors++; $display("FAIL reset_pre_send got %b exp 1", bus.ps2_tx_v_o); end
    #4 resetn = 1'b0;
    #1;
    checks++; if (bus.ps2_tx_v_o !== 1'b0) begin errors++; $display("FAIL reset_async_tx_v got %b exp 0", bus.ps2_tx_v_o); end
    checks++; if (bus.stat_o !== 8'h00)    begin errors++; $display("FAIL reset_async_stat got %h exp 00", bus.stat_o); end
    tick(2);
    resetn = 1'b1;
    tick(2);
    $display("test_reset done: checks %0d errors %0d", checks, errors);
  endtask

  task automatic test_single();
    logic [7:0] got, exp;
    push_cmd(1'b1, 8'hFF);
    exp_tx.push_back(8'hFF);
    checks++; if (bus.stat_o !== 8'h00)    begin errors++; $display("FAIL single_stat_prepop got %h exp 00", bus.stat_o); end
    tick();
    checks++; if (bus.stat_o !== 8'h01)    begin errors++; $display("FAIL single_stat_pop got %h exp 01", bus.stat_o); end
    checks++; if (bus.ps2_tx_v_o !== 1'b0) begin errors++; $display("FAIL single_tx_v_pop got %b exp 0", bus.ps2_tx_v_o); end
    tick();
    checks++; if (bus.ps2_tx_v_o !== 1'b1) begin errors++; $display("FAIL single_tx_v_n2 got %b exp 1", bus.ps2_tx_v_o); end
    serve_tx(got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL single_tx got %h exp %h", got, exp); end
    checks++; if (bus.ps2_tx_v_o !== 1'b0) begin errors++; $display("FAIL single_tx_v_drop got %b exp 0", bus.ps2_tx_v_o); end
    reply(8'hFA);
    checks++; if (bus.stat_o !== 8'hFA)    begin errors++; $display("FAIL single_stat_ack got %h exp FA", bus.stat_o); end
    checks++; if (bus.rvalid_o !== 1'b0)   begin errors++; $display("FAIL single_rx_empty got %b exp 0", bus.rvalid_o); end
    $display("test_single: sent %h stat %h", got, bus.stat_o);
  endtask

  task automatic test_sequence();
    logic [7:0] got, exp;
    logic [7:0] bytes [3];
    bytes[0] = 8'hED; bytes[1] = 8'h02; bytes[2] = 8'h07;
    for (int i = 0; i < 3; i++) begin
      push_cmd(i == 2, bytes[i]);
      exp_tx.push_back(bytes[i]);
    end
    for (int i = 0; i < 3; i++) begin
      serve_tx(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL seq_tx%0d got %h exp %h", i, got, exp); end
      reply(8'hFA);
      exp = (i == 2) ? 8'hFA : 8'h01;
      checks++; if (bus.stat_o !== exp) begin errors++; $display("FAIL seq_stat%0d got %h exp %h", i, bus.stat_o, exp); end
      $display("test_sequence: byte %0d sent %h stat %h", i, got, bus.stat_o);
    end
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL seq_rx_empty got %b exp 0", bus.rvalid_o); end
  endtask

  task automatic test_retry();
    logic [7:0] got, exp;
    bit seen;
    push_cmd(1'b1, 8'hF4);
    repeat (3) exp_tx.push_back(8'hF4);
    for (int i = 0; i < 3; i++) begin
      serve_tx(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL retry_tx%0d got %h exp %h", i, got, exp); end
      if (i == 0) reply(8'hFE);
      else if (i == 1) line_err();
      else reply(8'hFA);
      exp = (i == 2) ? 8'hFA : 8'h01;
      checks++; if (bus.stat_o !== exp) begin errors++; $display("FAIL retry_stat%0d got %h exp %h", i, bus.stat_o, exp); end
      $display("test_retry: attempt %0d sent %h stat %h", i, got, bus.stat_o);
    end
    push_cmd(1'b1, 8'hF4);
    push_cmd(1'b1, 8'hAA);
    repeat (3) exp_tx.push_back(8'hF4);
    for (int i = 0; i < 3; i++) begin
      serve_tx(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL exhaust_tx%0d got %h exp %h", i, got, exp); end
      reply(8'hFE);
    end
    checks++; if (bus.stat_o !== 8'hFE) begin errors++; $display("FAIL exhaust_stat got %h exp FE", bus.stat_o); end
    quiet(20, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL exhaust_flushed got tx_v seen %b exp 0", seen); end
    checks++; if (bus.tx_full_o !== 1'b0) begin errors++; $display("FAIL exhaust_tx_full got %b exp 0", bus.tx_full_o); end
    checks++; if (bus.rvalid_o !== 1'b0)  begin errors++; $display("FAIL exhaust_rx_empty got %b exp 0", bus.rvalid_o); end
    $display("test_retry: exhausted stat %h", bus.stat_o);
  endtask

  task automatic test_timeout();
    logic [7:0] got, exp;
    bit seen;
    push_cmd(1'b0, 8'hF3);
    push_cmd(1'b1, 8'h07);
    exp_tx.push_back(8'hF3);
    serve_tx(got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL tmo_tx got %h exp %h", got, exp); end
    repeat (49) us_pulse();
    checks++; if (bus.stat_o !== 8'h01) begin errors++; $display("FAIL tmo_early got %h exp 01", bus.stat_o); end
    us_pulse();
    tick();
    checks++; if (bus.stat_o !== 8'hFD) begin errors++; $display("FAIL tmo_stat got %h exp FD", bus.stat_o); end
    quiet(20, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL tmo_flushed got tx_v seen %b exp 0", seen); end
    $display("test_timeout: stat %h after 50 pulses", bus.stat_o);
  endtask

  task automatic test_interleave();
    logic [7:0] got, exp;
    logic v;
    bit seen;
    push_cmd(1'b1, 8'hF2);
    exp_tx.push_back(8'hF2);
    serve_tx(got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL intl_tx got %h exp %h", got, exp); end
    reply(8'h1C);
    exp_rx.push_back(8'h1C);
    checks++; if (bus.stat_o !== 8'h01) begin errors++; $display("FAIL intl_stat_mid got %h exp 01", bus.stat_o); end
    reply(8'hFA);
    checks++; if (bus.stat_o !== 8'hFA) begin errors++; $display("FAIL intl_stat got %h exp FA", bus.stat_o); end
    read_rx(got, v);
    exp = exp_rx.pop_front();
    checks++; if (v !== 1'b1 || got !== exp) begin errors++; $display("FAIL intl_rx got v%b %h exp v1 %h", v, got, exp); end
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL intl_rx_empty got %b exp 0", bus.rvalid_o); end
    $display("test_interleave: rx %h stat %h", got, bus.stat_o);
    push_cmd(1'b1, 8'hFF);
    push_cmd(1'b1, 8'hEE);
    exp_tx.push_back(8'hFF);
    serve_tx(got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL fc_tx got %h exp %h", got, exp); end
    reply(8'hFC);
    exp_rx.push_back(8'hFC);
    checks++; if (bus.stat_o !== 8'hFE) begin errors++; $display("FAIL fc_stat got %h exp FE", bus.stat_o); end
    quiet(20, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL fc_flushed got tx_v seen %b exp 0", seen); end
    read_rx(got, v);
    exp = exp_rx.pop_front();
    checks++; if (v !== 1'b1 || got !== exp) begin errors++; $display("FAIL fc_rx got v%b %h exp v1 %h", v, got, exp); end
    $display("test_interleave: FC rx %h stat %h", got, bus.stat_o);
  endtask

  task automatic test_overflow();
    logic [7:0] got, exp;
    logic v;
    for (int i = 0; i < 8; i++) begin
      reply(8'h10 + 8'(i));
      exp_rx.push_back(8'h10 + 8'(i));
    end
    checks++; if (bus.rx_ovf_o !== 1'b0) begin errors++; $display("FAIL rxfill_ovf got %b exp 0", bus.rx_ovf_o); end
    reply(8'h18);
    exp = exp_rx[0];
    checks++; if (bus.rx_ovf_o !== 1'b1) begin errors++; $display("FAIL rx_ovf got %b exp 1", bus.rx_ovf_o); end
    checks++; if (bus.rdata_o !== exp)   begin errors++; $display("FAIL rx_ovf_head got %h exp %h", bus.rdata_o, exp); end
    push_cmd(1'b1, 8'hA0);
    exp_tx.push_back(8'hA0);
    serve_tx(got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL stall_tx got %h exp %h", got, exp); end
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b1, 8'hB0 + 8'(i));
      if (i < 4) exp_tx.push_back(8'hB0 + 8'(i));
    end
    checks++; if (bus.tx_full_o !== 1'b1) begin errors++; $display("FAIL tx_full got %b exp 1", bus.tx_full_o); end
    checks++; if (bus.tx_ovf_o !== 1'b1)  begin errors++; $display("FAIL tx_ovf got %b exp 1", bus.tx_ovf_o); end
    bus.ovf_clr_i = 1'b1;
    tick();
    bus.ovf_clr_i = 1'b0;
    checks++; if (bus.rx_ovf_o !== 1'b0 || bus.tx_ovf_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got rx%b tx%b exp rx0 tx0", bus.rx_ovf_o, bus.tx_ovf_o);
    end
    bus.ovf_clr_i = 1'b1;
    push_cmd(1'b1, 8'hB5);
    bus.ovf_clr_i = 1'b0;
    checks++; if (bus.tx_ovf_o !== 1'b1) begin errors++; $display("FAIL clr_vs_ovf got %b exp 1", bus.tx_ovf_o); end
    bus.ovf_clr_i = 1'b1;
    tick();
    bus.ovf_clr_i = 1'b0;
    reply(8'hFA);
    push_cmd(1'b1, 8'hC0);
    exp_tx.push_back(8'hC0);
    checks++; if (bus.tx_ovf_o !== 1'b0)  begin errors++; $display("FAIL push_pop_full_ovf got %b exp 0", bus.tx_ovf_o); end
    checks++; if (bus.tx_full_o !== 1'b1) begin errors++; $display("FAIL push_pop_full got %b exp 1", bus.tx_full_o); end
    for (int i = 0; i < 5; i++) begin
      serve_tx(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL drain_tx%0d got %h exp %h", i, got, exp); end
      reply(8'hFA);
      $display("test_overflow: drained tx %h stat %h", got, bus.stat_o);
    end
    checks++; if (bus.stat_o !== 8'hFA) begin errors++; $display("FAIL drain_stat got %h exp FA", bus.stat_o); end
    bus.rdeq_i     = 1'b1;
    bus.ps2_rx_i   = 8'h19;
    bus.ps2_rx_v_i = 1'b1;
    tick();
    bus.rdeq_i     = 1'b0;
    bus.ps2_rx_v_i = 1'b0;
    void'(exp_rx.pop_front());
    exp_rx.push_back(8'h19);
    checks++; if (bus.rx_ovf_o !== 1'b0) begin errors++; $display("FAIL rx_deq_wr_full got %b exp 0", bus.rx_ovf_o); end
    for (int i = 0; i < 8; i++) begin
      read_rx(got, v);
      exp = exp_rx.pop_front();
      checks++; if (v !== 1'b1 || got !== exp) begin errors++; $display("FAIL rx_drain%0d got v%b %h exp v1 %h", i, v, got, exp); end
      $display("test_overflow: rx %h", got);
    end
    read_rx(got, v);
    checks++; if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== 8'h00) begin
      errors++; $display("FAIL rx_deq_empty got v%b %h exp v0 00", bus.rvalid_o, bus.rdata_o);
    end
  endtask

  initial begin
    bus.rdeq_i        = 1'b0;
    bus.wdata_i       = 8'h00;
    bus.wlast_i       = 1'b0;
    bus.wenq_i        = 1'b0;
    bus.ovf_clr_i     = 1'b0;
    bus.ps2_rx_i      = 8'h00;
    bus.ps2_rx_v_i    = 1'b0;
    bus.ps2_tx_deq_i  = 1'b0;
    bus.ps2_tx_errd_i = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_retry();
    test_timeout();
    test_interleave();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_host_seq.md
# ps2_host_seq

Parametrised command/reply sequencer for one PS2 channel (keyboard or mouse), placed between the CPU-facing register block and an existing `ps2_port` instance. It buffers received bytes and sends multi-byte host commands one byte at a time, waiting for each reply before sending the next. It swallows intermediate ACKs and retransmits a byte when the device answers RESEND (0xFE), up to a bounded retry count. It also applies a reply timeout and reports the outcome in a status register.

## Interface
Parameters:
- `RXDEPTH_LOG2`, 3: RX FIFO holds 2**RXDEPTH_LOG2 bytes.
- `TXDEPTH_LOG2`, 2: TX FIFO holds 2**TXDEPTH_LOG2 entries of {last, byte}.
- `MAX_RETRY`, 2: RESEND retransmissions allowed per byte (0..7).
- `TIMEOUT_US`, 20000: reply timeout, counted in `ck1us` pulses.

Ports (clock and reset first):
- `clk6x`  in  1  48 MHz clock, single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `ck1us`  in  1  one-cycle pulse every 1 µs.
- `rdata_o`  out  8  RX FIFO head; 0x00 when empty.
- `rvalid_o`  out  1  RX FIFO not empty.
- `rdeq_i`  in  1  pop RX head; ignored when empty.
- `wdata_i`  in  8  command/data byte to push.
- `wlast_i`  in  1  pushed byte is the last of its command sequence.
- `wenq_i`  in  1  push {wlast_i, wdata_i} into TX FIFO.
- `stat_o`  out  8  0x00 idle, 0x01 pending, 0xFA ack, 0xFE err, 0xFD timeout.
- `tx_full_o`  out  1  TX FIFO full.
- `rx_ovf_o`  out  1  sticky: an RX byte was dropped.
- `tx_ovf_o`  out  1  sticky: a push was dropped.
- `ovf_clr_i`  in  1  clear both sticky flags.
- `ps2_rx_i`  in  8  received byte from `ps2_port`.
- `ps2_rx_v_i`  in  1  received byte valid (1-cycle pulse).
- `ps2_tx_o`  out  8  byte to transmit.
- `ps2_tx_v_o`  out  1  transmit request.
- `ps2_tx_deq_i`  in  1  `ps2_port` consumed `ps2_tx_o`; transmission started.
- `ps2_tx_errd_i`  in  1  device gave no line-ACK bit.

## Operation
- FSM states: IDLE, LOAD, SEND, WAIT.
- **IDLE**
  - When the TX FIFO is non-empty: pop the head into `txbuf` {last, byte}, clear the retry counter, set `stat_o`=0x01, go to SEND.
- **LOAD**
  - Entered after an intermediate ACK.
  - Waits indefinitely for a TX FIFO entry, then pops it into `txbuf`, clears retry, goes to SEND.
- **SEND**
  - `ps2_tx_v_o`=1 and `ps2_tx_o`=`txbuf.byte`.
  - On `ps2_tx_deq_i`: drop `ps2_tx_v_o` and clear the timeout counter, both in the same edge; go to WAIT.
- **WAIT** (replies are handled in the following priority order)
  - `ps2_rx_v_i` with 0xFA:
    - If `txbuf.last`: set `stat_o`=0xFA, go to IDLE.
    - Otherwise: go to LOAD.
    - The 0xFA is never written to the RX FIFO.
  - `ps2_rx_v_i` with 0xFE:
    - If retry < MAX_RETRY: increment retry, go to SEND with the same byte.
    - Otherwise: set `stat_o`=0xFE, flush the TX FIFO, go to IDLE.
    - The 0xFE is never written to the RX FIFO.
  - `ps2_rx_v_i` with 0xFC: set `stat_o`=0xFE, flush, go to IDLE. The 0xFC is also written to the RX FIFO.
  - `ps2_tx_errd_i`: treated exactly as a 0xFE reply.
  - Timeout counter reaches TIMEOUT_US: set `stat_o`=0xFD, flush, go to IDLE.
  - Any other received byte: written to the RX FIFO; the FSM stays in WAIT.
- **Flush**
  - Synchronous clear of the TX FIFO.
  - Ends the current command sequence and any queued sequences that follow it.
- **RX path**
  - Every `ps2_rx_v_i` byte outside WAIT goes to the RX FIFO.
  - If the RX FIFO is full, the byte is dropped and `rx_ovf_o` is set.
- **TX push**
  - `wenq_i` while the TX FIFO is full: entry dropped, `tx_ovf_o` set.
- `stat_o` holds its last final value (0xFA/0xFE/0xFD) until the next sequence starts.
- Counter widths: timeout counter is $clog2(TIMEOUT_US+1) bits; retry counter is 3 bits.

## Timing
- Reset (async assert, sync release) state:
  - FSM in IDLE.
  - FIFOs empty.
  - `stat_o`=0x00, `ps2_tx_v_o`=0, `ps2_tx_o`=0x00.
  - `rvalid_o`=0, `rdata_o`=0x00, `tx_full_o`=0.
  - `rx_ovf_o`=0, `tx_ovf_o`=0.
- Reset during SEND or WAIT: abandons the transfer; no status is preserved.
- All outputs are registered except `rdata_o`, `rvalid_o` and `tx_full_o` (combinational from FIFO state).
- Push to SEND:
  - An entry pushed at edge N into an empty FIFO in IDLE is popped at N+1.
  - `ps2_tx_v_o`=1 from N+2.
- `stat_o` becomes 0x01 on the pop edge.
- Simultaneous `wenq_i` and pop on a full TX FIFO: the push is accepted.
- Simultaneous `rdeq_i` and RX write on a full RX FIFO: the write is accepted, no overflow.
- Simultaneous flush and `wenq_i`: flush wins; the push is lost and `tx_ovf_o` is not set.
- Simultaneous timeout and reply: the reply wins.
- `ovf_clr_i` together with a new overflow event: the flag stays set.
- `rdeq_i` on an empty RX FIFO: no effect.

## Test plan
- **1-byte command with ACK:** push {1,0xFF}; device replies 0xFA → `stat_o` 0x01 then 0xFA; RX FIFO stays empty.
- **3-byte sequence:** push {0,0xED},{0,0x02},{1,0x07}; device replies 0xFA each time → three transmissions in order; `stat_o`=0xFA only after the third reply; the two intermediate ACKs are not in the RX FIFO.
- **RESEND retry:** MAX_RETRY=2; device answers 0xFE twice, then 0xFA → 0xF4 is transmitted three times; `stat_o`=0xFA. With 3× 0xFE → `stat_o`=0xFE and the TX FIFO is empty.
- **Timeout:** TIMEOUT_US=50; no reply after `ps2_tx_deq_i` → `stat_o`=0xFD after the 50th `ck1us`; queued {1,0x07} is flushed and never sent.
- **Interleaved scan code:** during WAIT, device sends 0x1C then 0xFA → RX FIFO contains 0x1C only; `stat_o`=0xFA.
- **Overflow:** fill the RX FIFO (8 bytes), send a 9th → `rx_ovf_o`=1 and `rdata_o` is still the first byte. Push 5 entries into a 4-deep TX FIFO while stalled → `tx_ovf_o`=1. `ovf_clr_i` clears both flags.
